// File: rtl/udp_ip_pkg.sv
// Shared constants and state encoding for the UDP/IPv4 frame transmitter.
package udp_ip_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

  localparam int unsigned ETH_HDR_LEN   = 14;
  localparam int unsigned IP_HDR_LEN    = 20;
  localparam int unsigned UDP_HDR_LEN   = 8;
  localparam int unsigned MIN_FRAME_LEN = 60;

  // Ethernet + IPv4 + UDP header bytes emitted ahead of the payload.
  localparam int unsigned HDR_LEN = ETH_HDR_LEN + IP_HDR_LEN + UDP_HDR_LEN;

  typedef enum logic [2:0] {
    StIdle,
    StCksum,
    StHeader,
    StPayload,
    StPad
  } tx_state_e;

endpackage

// File: rtl/ip_checksum.sv
// Two-stage registered IPv4 header checksum over ten 16-bit words.
module ip_checksum (
  input  logic             clock,
  input  logic             reset,
  input  logic [9:0][15:0] words,
  output logic [15:0]      checksum
);

  logic [19:0] sum_d, sum_q;
  logic [16:0] fold1;
  logic [15:0] fold2;
  logic [15:0] csum_q;

  // Plain binary sum of the ten words; 20 bits cannot overflow.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < 10; i++) begin
      sum_d = sum_d + 20'(words[i]);
    end
  end

  // Two end-around folds are enough: the first leaves at most a single carry.
  always_comb begin
    fold1 = {1'b0, sum_q[15:0]} + 17'(sum_q[19:16]);
    fold2 = fold1[15:0] + 16'(fold1[16]);
  end

  // Stage 1 registers the raw sum, stage 2 the folded complement.
  always_ff @(posedge clock) begin
    if (reset) begin
      sum_q  <= '0;
      csum_q <= '0;
    end else begin
      sum_q  <= sum_d;
      csum_q <= ~fold2;
    end
  end

  assign checksum = csum_q;

endmodule

// File: rtl/udp_ip_tx.sv
// UDP/IPv4 over Ethernet frame builder: header from latched fields, streamed
// payload, zero padding up to the Ethernet minimum frame size.
module udp_ip_tx
  import udp_ip_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 1472,
  parameter int unsigned IP_TTL      = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [47:0] mac_in,
  input  logic [31:0] ip_in,
  input  logic [15:0] port_in,
  input  logic [47:0] dst_mac_in,
  input  logic [31:0] dst_ip_in,
  input  logic [15:0] dst_port_in,
  input  logic        tx_start_in,
  input  logic [10:0] payload_len_in,
  output logic        tx_busy_out,
  output logic        tx_error_out,
  input  logic [7:0]  payload_data_in,
  input  logic        payload_valid_in,
  output logic        payload_ready_out,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        last_out,
  input  logic        ready_in
);

  localparam int unsigned HdrBits = HDR_LEN * 8;
  localparam logic [10:0] NoPadLen = 11'(MIN_FRAME_LEN - HDR_LEN);

  tx_state_e   state_q;
  logic [47:0] mac_q, dst_mac_q;
  logic [31:0] ip_q, dst_ip_q;
  logic [15:0] port_q, dst_port_q;
  logic [10:0] len_q;
  logic [15:0] ip_id_q;
  logic [5:0]  hdr_cnt_q;
  logic [10:0] cnt_q;
  logic        tx_error_q;

  logic [15:0]        total_len, udp_len, checksum;
  logic               needs_pad, payload_last, pad_last, len_ok, fire;
  logic [10:0]        pad_len;
  logic [9:0][15:0]   cksum_words;
  logic [HdrBits-1:0] hdr_vec, hdr_shift;
  logic [7:0]         hdr_byte;

  assign total_len = 16'(IP_HDR_LEN + UDP_HDR_LEN) + 16'(len_q);
  assign udp_len   = 16'(UDP_HDR_LEN) + 16'(len_q);
  assign needs_pad = len_q < NoPadLen;
  assign pad_len   = NoPadLen - len_q;
  assign len_ok    = (payload_len_in != '0) && (32'(payload_len_in) <= MAX_PAYLOAD);

  assign payload_last = cnt_q == (len_q - 11'd1);
  assign pad_last     = cnt_q == (pad_len - 11'd1);

  assign cksum_words = {16'h4500, total_len, ip_id_q, 16'h4000, {8'(IP_TTL), IP_PROTO_UDP},
                        16'h0000, ip_q[31:16], ip_q[15:0], dst_ip_q[31:16], dst_ip_q[15:0]};

  ip_checksum u_ip_checksum (
    .clock    (clock),
    .reset    (reset),
    .words    (cksum_words),
    .checksum (checksum)
  );

  // Header is a flat view of the latched fields; the byte counter shifts the
  // wanted byte to the top so the MSB-first order falls out naturally.
  assign hdr_vec = {dst_mac_q, mac_q, ETHERTYPE_IPV4,
                    8'h45, 8'h00, total_len, ip_id_q, 16'h4000, 8'(IP_TTL), IP_PROTO_UDP,
                    checksum, ip_q, dst_ip_q,
                    port_q, dst_port_q, udp_len, 16'h0000};
  assign hdr_shift = hdr_vec << {hdr_cnt_q, 3'b000};
  assign hdr_byte  = hdr_shift[HdrBits-1 -: 8];

  // Output stream: header/pad from the counters, payload passed straight through.
  always_comb begin
    data_out          = 8'h00;
    valid_out         = 1'b0;
    last_out          = 1'b0;
    payload_ready_out = 1'b0;
    unique case (state_q)
      StHeader: begin
        data_out  = hdr_byte;
        valid_out = 1'b1;
      end
      StPayload: begin
        data_out          = payload_data_in;
        valid_out         = payload_valid_in;
        last_out          = payload_last && !needs_pad;
        payload_ready_out = ready_in;
      end
      StPad: begin
        valid_out = 1'b1;
        last_out  = pad_last;
      end
      default: ;
    endcase
  end

  assign fire         = valid_out && ready_in;
  assign tx_busy_out  = state_q != StIdle;
  assign tx_error_out = tx_error_q;

  // Frame sequencing, field capture, IP ID and error pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      mac_q      <= '0;
      dst_mac_q  <= '0;
      ip_q       <= '0;
      dst_ip_q   <= '0;
      port_q     <= '0;
      dst_port_q <= '0;
      len_q      <= '0;
      ip_id_q    <= '0;
      hdr_cnt_q  <= '0;
      cnt_q      <= '0;
      tx_error_q <= 1'b0;
    end else begin
      tx_error_q <= 1'b0;
      if (fire && last_out) begin
        ip_id_q <= ip_id_q + 16'd1;
      end
      unique case (state_q)
        StIdle: begin
          if (tx_start_in) begin
            if (len_ok) begin
              mac_q      <= mac_in;
              dst_mac_q  <= dst_mac_in;
              ip_q       <= ip_in;
              dst_ip_q   <= dst_ip_in;
              port_q     <= port_in;
              dst_port_q <= dst_port_in;
              len_q      <= payload_len_in;
              hdr_cnt_q  <= '0;
              state_q    <= StCksum;
            end else begin
              tx_error_q <= 1'b1;
            end
          end
        end
        // Two cycles let the checksum pipeline settle on the latched fields.
        StCksum: begin
          if (hdr_cnt_q == 6'd0) begin
            hdr_cnt_q <= 6'd1;
          end else begin
            hdr_cnt_q <= '0;
            state_q   <= StHeader;
          end
        end
        StHeader: begin
          if (fire) begin
            if (hdr_cnt_q == 6'(HDR_LEN - 1)) begin
              cnt_q   <= '0;
              state_q <= StPayload;
            end else begin
              hdr_cnt_q <= hdr_cnt_q + 6'd1;
            end
          end
        end
        StPayload: begin
          if (fire) begin
            if (payload_last) begin
              cnt_q   <= '0;
              state_q <= needs_pad ? StPad : StIdle;
            end else begin
              cnt_q <= cnt_q + 11'd1;
            end
          end
        end
        StPad: begin
          if (fire) begin
            if (pad_last) begin
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q + 11'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_ip_tx.sv
// Self-checking bench for udp_ip_tx: a byte-queue frame model built from the
// protocol rules, checked on every transfer, plus literal pins on the model.
module tb_udp_ip_tx;

  logic        clock = 1'b0;
  logic        reset;
  logic [47:0] src_mac  = 48'h02_00_00_00_00_01;
  logic [47:0] dst_mac  = 48'h02_00_00_00_00_02;
  logic [31:0] src_ip   = 32'hC0A8_000A;
  logic [31:0] dst_ip   = 32'hC0A8_0014;
  logic [15:0] src_port = 16'h1234;
  logic [15:0] dst_port = 16'h5678;
  logic        tx_start_in;
  logic [10:0] payload_len_in;
  logic        tx_busy_out, tx_error_out;
  logic [7:0]  payload_data_in;
  logic        payload_valid_in, payload_ready_out;
  logic [7:0]  data_out;
  logic        valid_out, last_out, ready_in;

  always #5 clock = ~clock;

  udp_ip_tx dut (
    .clock             (clock),
    .reset             (reset),
    .mac_in            (src_mac),
    .ip_in             (src_ip),
    .port_in           (src_port),
    .dst_mac_in        (dst_mac),
    .dst_ip_in         (dst_ip),
    .dst_port_in       (dst_port),
    .tx_start_in       (tx_start_in),
    .payload_len_in    (payload_len_in),
    .tx_busy_out       (tx_busy_out),
    .tx_error_out      (tx_error_out),
    .payload_data_in   (payload_data_in),
    .payload_valid_in  (payload_valid_in),
    .payload_ready_out (payload_ready_out),
    .data_out          (data_out),
    .valid_out         (valid_out),
    .last_out          (last_out),
    .ready_in          (ready_in)
  );

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  int          frames_done = 0;
  int          rx_cnt = 0;
  int          err_pulses = 0;
  logic        rand_mode = 1'b0;
  logic        gap_mode = 1'b0;
  int          pidx = 0;
  int          cur_len = 0;
  logic [7:0]  cur_seed = 8'h00;
  logic        pay_fire = 1'b0;
  logic [15:0] mdl_id = 16'h0000;
  logic        stall_prev = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  logic        prev_last = 1'b0;

  function automatic logic [7:0] pbyte(logic [7:0] seed, int i);
    return seed + 8'(i * 3);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic void push16(logic [15:0] v);
    exp_q.push_back(v[15:8]);
    exp_q.push_back(v[7:0]);
  endfunction

  function automatic void push48(logic [47:0] v);
    for (int i = 5; i >= 0; i--) exp_q.push_back(v[i*8 +: 8]);
  endfunction

  // Expected frame straight from the protocol layout.
  task automatic build_frame(int len, logic [7:0] seed, logic [15:0] id);
    logic [15:0] w[10];
    int unsigned s;
    logic [15:0] ck;
    w[0] = 16'h4500;  w[1] = 16'(28 + len); w[2] = id;  w[3] = 16'h4000;
    w[4] = 16'h4011;  w[5] = 16'h0000;
    w[6] = src_ip[31:16]; w[7] = src_ip[15:0]; w[8] = dst_ip[31:16]; w[9] = dst_ip[15:0];
    s = 0;
    for (int i = 0; i < 10; i++) s += 32'(w[i]);
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    ck = ~s[15:0];
    push48(dst_mac);
    push48(src_mac);
    push16(16'h0800);
    for (int i = 0; i < 10; i++) push16((i == 5) ? ck : w[i]);
    push16(src_port);
    push16(dst_port);
    push16(16'(8 + len));
    push16(16'h0000);
    for (int i = 0; i < len; i++) exp_q.push_back(pbyte(seed, i));
    while (exp_q.size() < 60) exp_q.push_back(8'h00);
  endtask

  // Transfer checker and stall-stability checker.
  always @(negedge clock) begin
    logic [7:0] e;
    pay_fire = payload_valid_in && payload_ready_out && !reset;
    if (tx_error_out && !reset) err_pulses++;
    if (!reset && stall_prev) begin
      check("stall_valid", valid_out, 1);
      check("stall_data", data_out, prev_data);
      check("stall_last", last_out, prev_last);
    end
    stall_prev = !reset && valid_out && !ready_in;
    prev_data  = data_out;
    prev_last  = last_out;
    if (!reset && valid_out && ready_in) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_byte actual=0x%0h required=none", data_out);
      end else begin
        e = exp_q.pop_front();
        check("frame_byte", data_out, e);
        check("frame_last", last_out, exp_q.size() == 0);
      end
      rx_cnt++;
      if (last_out) frames_done++;
    end
  end

  // Payload source and ready generator; valid is held until it is taken.
  always @(posedge clock) begin
    #1;
    if (!tx_busy_out) pidx = 0;
    else if (pay_fire) pidx++;
    ready_in = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (!tx_busy_out || !(payload_valid_in && !pay_fire)) begin
      payload_valid_in = tx_busy_out && (pidx < cur_len) &&
                         (!gap_mode || ($urandom_range(0, 3) != 0));
    end
    payload_data_in = pbyte(cur_seed, pidx);
  end

  task automatic start_frame(int len, logic [7:0] seed, logic ok);
    cur_len  = len;
    cur_seed = seed;
    @(posedge clock); #1;
    tx_start_in    = 1'b1;
    payload_len_in = 11'(len);
    @(posedge clock); #1;
    tx_start_in = 1'b0;
    if (ok) begin
      check("start_busy", tx_busy_out, 1);
      check("start_valid_c1", valid_out, 0);
      @(posedge clock); #1;
      check("start_valid_c2", valid_out, 0);
      @(posedge clock); #1;
      check("start_valid_c3", valid_out, 1);
    end else begin
      check("reject_error", tx_error_out, 1);
      check("reject_busy", tx_busy_out, 0);
      @(posedge clock); #1;
      check("reject_error_off", tx_error_out, 0);
      for (int i = 0; i < 4; i++) begin
        @(posedge clock); #1;
        check("reject_valid", valid_out, 0);
      end
    end
  endtask

  task automatic wait_frames(int target, int exp_len, int rx0);
    int n = 0;
    while (frames_done < target && n < 8000) begin
      @(negedge clock);
      n++;
    end
    check("frame_done", frames_done, target);
    check("frame_len", rx_cnt - rx0, exp_len);
    check("model_drained", exp_q.size(), 0);
  endtask

  initial begin
    int nf;
    int rx0;
    nf = 0;
    reset = 1'b1;
    tx_start_in = 1'b0;
    payload_len_in = '0;
    payload_valid_in = 1'b0;
    payload_data_in = 8'h00;
    ready_in = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", valid_out, 0);
    check("rst_last", last_out, 0);
    check("rst_data", data_out, 0);
    check("rst_pready", payload_ready_out, 0);
    check("rst_busy", tx_busy_out, 0);
    check("rst_error", tx_error_out, 0);
    reset = 1'b0;

    // Reference frame: L=4, ID 0.
    build_frame(4, 8'h10, mdl_id);
    check("pin_size_l4", exp_q.size(), 60);
    check("pin_ck_hi", exp_q[24], 8'hB9);
    check("pin_ck_lo", exp_q[25], 8'h5E);
    check("pin_iplen_hi", exp_q[16], 8'h00);
    check("pin_iplen_lo", exp_q[17], 8'h20);
    check("pin_udplen_lo", exp_q[39], 8'h0C);
    rx0 = rx_cnt;
    start_frame(4, 8'h10, 1'b1);
    nf++;
    wait_frames(nf, 60, rx0);
    mdl_id++;

    start_frame(0, 8'h00, 1'b0);
    start_frame(1473, 8'h00, 1'b0);

    // L=18: no padding; a start pulse mid-frame must be ignored.
    build_frame(18, 8'h40, mdl_id);
    check("pin_size_l18", exp_q.size(), 60);
    rx0 = rx_cnt;
    start_frame(18, 8'h40, 1'b1);
    tx_start_in = 1'b1;
    payload_len_in = '0;
    @(posedge clock); #1;
    tx_start_in = 1'b0;
    check("busy_start_no_error", tx_error_out, 0);
    nf++;
    wait_frames(nf, 60, rx0);
    mdl_id++;

    // L=17: one pad byte.
    build_frame(17, 8'h77, mdl_id);
    rx0 = rx_cnt;
    start_frame(17, 8'h77, 1'b1);
    nf++;
    wait_frames(nf, 60, rx0);
    mdl_id++;

    // Back-pressure and payload gaps.
    rand_mode = 1'b1;
    gap_mode  = 1'b1;
    build_frame(100, 8'hA5, mdl_id);
    rx0 = rx_cnt;
    start_frame(100, 8'hA5, 1'b1);
    nf++;
    wait_frames(nf, 142, rx0);
    mdl_id++;
    rand_mode = 1'b0;
    gap_mode  = 1'b0;

    // Reset in the middle of the payload abandons the frame.
    build_frame(20, 8'h33, mdl_id);
    start_frame(20, 8'h33, 1'b1);
    begin
      int n = 0;
      while (pidx < 3 && n < 2000) begin
        @(negedge clock);
        n++;
      end
      check("reset_reach_byte3", pidx >= 3, 1);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("midrst_valid", valid_out, 0);
    check("midrst_last", last_out, 0);
    check("midrst_busy", tx_busy_out, 0);
    check("midrst_pready", payload_ready_out, 0);
    reset = 1'b0;
    exp_q.delete();
    mdl_id = 16'h0000;

    // Back-to-back frames after reset carry IDs 0 and 1.
    build_frame(10, 8'h05, mdl_id);
    check("pin_id0_lo", exp_q[19], 8'h00);
    rx0 = rx_cnt;
    start_frame(10, 8'h05, 1'b1);
    nf++;
    wait_frames(nf, 60, rx0);
    mdl_id++;
    build_frame(5, 8'h90, mdl_id);
    check("pin_id1_hi", exp_q[18], 8'h00);
    check("pin_id1_lo", exp_q[19], 8'h01);
    rx0 = rx_cnt;
    start_frame(5, 8'h90, 1'b1);
    nf++;
    wait_frames(nf, 60, rx0);
    mdl_id++;

    // Largest payload.
    build_frame(1472, 8'h21, mdl_id);
    check("pin_size_max", exp_q.size(), 1514);
    check("pin_iplen_max_hi", exp_q[16], 8'h05);
    check("pin_iplen_max_lo", exp_q[17], 8'hDC);
    rx0 = rx_cnt;
    start_frame(1472, 8'h21, 1'b1);
    nf++;
    wait_frames(nf, 1514, rx0);
    mdl_id++;

    repeat (3) @(posedge clock);
    check("error_pulse_count", err_pulses, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
